// File: rtl/operand_loader.sv
// ---------------------------------------------------------------------------
// operand_loader
//
// Purpose:
//   Sits behind the instruction decoder and turns its load_weight /
//   load_input commands into reads of the unified operand memory (1-cycle
//   synchronous read). A weight load fills the N x N stationary weight
//   registers of the systolic array. An input load buffers an N x N
//   activation tile and then streams it into the array rows with a one-cycle
//   skew per row.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   load_weight    decoder level; rising edge starts a weight load
//   load_input     decoder level; rising edge starts an input load
//   base_address   tile start address, latched on the start edge
//   mem_rd_en      memory read strobe
//   mem_addr       memory read address (0 when not reading)
//   mem_rdata      read data, valid the cycle after mem_rd_en
//   weight_out     flat weights, entry r*N+c at [(r*N+c)*DATA_W +: DATA_W]
//   weights_valid  level, full weight set loaded
//   in_data        skewed activation rows, row r at [r*DATA_W +: DATA_W]
//   in_valid       per-row valid for in_data
//   busy           operation in progress (first cycle after start .. DONE)
//   done           one-cycle pulse when an operation completes
// ---------------------------------------------------------------------------
module operand_loader #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_weight,
    input  logic                    load_input,
    input  logic [ADDR_W-1:0]       base_address,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [N*N*DATA_W-1:0]   weight_out,
    output logic                    weights_valid,
    output logic [N*DATA_W-1:0]     in_data,
    output logic [N-1:0]            in_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int NN    = N * N;
    // Counter must reach NN-1 (read index) and 2N-2 (stream index).
    localparam int CNT_W = $clog2(NN + 2 * N);
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] W_READ   = 3'd1;
    localparam logic [2:0] W_CAP    = 3'd2;
    localparam logic [2:0] I_READ   = 3'd3;
    localparam logic [2:0] I_CAP    = 3'd4;
    localparam logic [2:0] I_STREAM = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wv_q, wv_d;
    logic              lw_q, li_q;

    // Read pipeline: remembers what the read issued last cycle was for.
    logic              rd_valid_q;
    logic              rd_is_w_q;
    logic [IDX_W-1:0]  rd_idx_q;

    logic [DATA_W-1:0] weight_q [NN];
    logic [DATA_W-1:0] ibuf_q   [NN];

    logic w_edge;
    logic i_edge;
    logic last_read;

    assign w_edge    = load_weight & ~lw_q;
    assign i_edge    = load_input & ~li_q;
    assign last_read = (cnt_q == CNT_W'(NN - 1));

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        wv_d    = wv_q;
        case (state_q)
            IDLE: begin
                // Weight has priority; a coincident input edge is dropped.
                if (w_edge) begin
                    state_d = W_READ;
                    cnt_d   = '0;
                    base_d  = base_address;
                    wv_d    = 1'b0;
                end else if (i_edge) begin
                    state_d = I_READ;
                    cnt_d   = '0;
                    base_d  = base_address;
                end
            end
            W_READ: begin
                if (last_read) begin
                    state_d = W_CAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            W_CAP: begin
                // Last weight lands at the end of this cycle, so the valid
                // flag rises together with done.
                state_d = DONE;
                wv_d    = 1'b1;
            end
            I_READ: begin
                if (last_read) begin
                    state_d = I_CAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            I_CAP: begin
                state_d = I_STREAM;
                cnt_d   = '0;
            end
            I_STREAM: begin
                if (cnt_q == CNT_W'(2 * N - 2)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            wv_q       <= 1'b0;
            lw_q       <= 1'b0;
            li_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_is_w_q  <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            wv_q       <= wv_d;
            lw_q       <= load_weight;
            li_q       <= load_input;
            rd_valid_q <= mem_rd_en;
            rd_is_w_q  <= (state_q == W_READ);
            rd_idx_q   <= cnt_q[IDX_W-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Operand storage: data returns one cycle after the read strobe
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NN; j++) begin
                weight_q[j] <= '0;
                ibuf_q[j]   <= '0;
            end
        end else if (rd_valid_q) begin
            if (rd_is_w_q) begin
                weight_q[rd_idx_q] <= mem_rdata;
            end else begin
                ibuf_q[rd_idx_q] <= mem_rdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign mem_rd_en     = (state_q == W_READ) || (state_q == I_READ);
    // Offset addition wraps modulo 2^ADDR_W.
    assign mem_addr      = mem_rd_en ? (base_q + ADDR_W'(cnt_q)) : '0;
    assign weights_valid = wv_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

    genvar gi;
    generate
        for (gi = 0; gi < NN; gi++) begin : g_wout
            assign weight_out[gi*DATA_W +: DATA_W] = weight_q[gi];
        end

        // Row r is delayed by r stream cycles: at stream step s it carries
        // buffer element (s-r, r) while 0 <= s-r < N.
        for (gi = 0; gi < N; gi++) begin : g_row
            logic             row_act;
            logic [CNT_W-1:0] k_row;
            logic [IDX_W-1:0] idx_row;

            assign row_act = (state_q == I_STREAM)
                          && (cnt_q >= CNT_W'(gi))
                          && (cnt_q <  CNT_W'(gi + N));
            assign k_row   = cnt_q - CNT_W'(gi);
            assign idx_row = IDX_W'(k_row * CNT_W'(N) + CNT_W'(gi));

            assign in_valid[gi]                 = row_act;
            assign in_data[gi*DATA_W +: DATA_W] = row_act ? ibuf_q[idx_row] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_operand_loader
//
// Directed bench for operand_loader (N=2, DATA_W=8, ADDR_W=13). A behavioural
// operand memory with a 1-cycle registered read sits on the memory port.
// Inputs change 1 time unit after the rising edge; outputs are sampled in the
// same window, so "cycle k" is the interval following the k-th edge after the
// start edge.
// ---------------------------------------------------------------------------
module tb_operand_loader;

    localparam int N      = 2;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 13;

    logic                  clk;
    logic                  reset;
    logic                  load_weight;
    logic                  load_input;
    logic [ADDR_W-1:0]     base_address;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_rdata;
    logic [N*N*DATA_W-1:0] weight_out;
    logic                  weights_valid;
    logic [N*DATA_W-1:0]   in_data;
    logic [N-1:0]          in_valid;
    logic                  busy;
    logic                  done;

    int vectors;
    int miscompares;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    operand_loader #(
        .N      (N),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_weight   (load_weight),
        .load_input    (load_input),
        .base_address  (base_address),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .weight_out    (weight_out),
        .weights_valid (weights_valid),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand memory: 1-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs a weight load from the current cycle (cycle 0) through the first
    // IDLE cycle (cycle 7). inj_cyc > 0 raises load_input in that cycle.
    task automatic weight_load(input logic [ADDR_W-1:0] base,
                               input logic [31:0] exp_w,
                               input int inj_cyc);
        logic [ADDR_W-1:0] exp_addr;
        load_weight  = 1'b1;
        base_address = base;
        check("w_c0_busy", 64'(busy), 64'd0);
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            if (c == 1) load_weight = 1'b0;
            if (c == inj_cyc) load_input = 1'b1;
            exp_addr = (c <= 4) ? ADDR_W'(base + ADDR_W'(c - 1)) : '0;
            check($sformatf("w_c%0d_rd_en", c), 64'(mem_rd_en), 64'(c <= 4));
            check($sformatf("w_c%0d_addr", c), 64'(mem_addr), 64'(exp_addr));
            check($sformatf("w_c%0d_busy", c), 64'(busy), 64'(c <= 6));
            check($sformatf("w_c%0d_done", c), 64'(done), 64'(c == 6));
            check($sformatf("w_c%0d_wvalid", c), 64'(weights_valid), 64'(c >= 6));
            check($sformatf("w_c%0d_in_valid", c), 64'(in_valid), 64'd0);
            if (c >= 6) check($sformatf("w_c%0d_weights", c), 64'(weight_out), 64'(exp_w));
        end
    endtask

    // Expected stream pattern for the input load, indexed by cycle 0..10.
    logic [1:0]  exp_iv [0:10];
    logic [15:0] exp_id [0:10];

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        load_weight  = 1'b0;
        load_input   = 1'b0;
        base_address = '0;

        for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'h00;
        mem[13'h100] = 8'd11; mem[13'h101] = 8'd22;
        mem[13'h102] = 8'd33; mem[13'h103] = 8'd44;
        mem[13'h020] = 8'd1;  mem[13'h021] = 8'd2;
        mem[13'h022] = 8'd3;  mem[13'h023] = 8'd4;
        mem[13'h1FFE] = 8'hA1; mem[13'h1FFF] = 8'hA2;
        mem[13'h0000] = 8'hA3; mem[13'h0001] = 8'hA4;

        for (int c = 0; c <= 10; c++) begin
            exp_iv[c] = 2'b00;
            exp_id[c] = 16'h0000;
        end
        exp_iv[6] = 2'b01; exp_id[6] = 16'h0001;
        exp_iv[7] = 2'b11; exp_id[7] = 16'h0203;
        exp_iv[8] = 2'b10; exp_id[8] = 16'h0400;

        // ---------------- reset state ----------------
        next_cycle();
        next_cycle();
        reset = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wvalid", 64'(weights_valid), 64'd0);
        check("rst_weights", 64'(weight_out), 64'd0);
        check("rst_in_valid", 64'(in_valid), 64'd0);
        check("rst_in_data", 64'(in_data), 64'd0);
        next_cycle();

        // ---------------- weight load, base 0x100 ----------------
        weight_load(13'h100, 32'h2C21160B, 0);
        next_cycle();

        // ---------------- input load, base 0x20 ----------------
        load_input   = 1'b1;
        base_address = 13'h020;
        check("i_c0_busy", 64'(busy), 64'd0);
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            if (c == 1) load_input = 1'b0;
            check($sformatf("i_c%0d_rd_en", c), 64'(mem_rd_en), 64'(c <= 4));
            check($sformatf("i_c%0d_addr", c), 64'(mem_addr),
                  (c <= 4) ? 64'(13'h020 + 13'(c - 1)) : 64'd0);
            check($sformatf("i_c%0d_busy", c), 64'(busy), 64'(c <= 9));
            check($sformatf("i_c%0d_done", c), 64'(done), 64'(c == 9));
            check($sformatf("i_c%0d_in_valid", c), 64'(in_valid), 64'(exp_iv[c]));
            check($sformatf("i_c%0d_in_data", c), 64'(in_data), 64'(exp_id[c]));
            check($sformatf("i_c%0d_weights", c), 64'(weight_out), 64'h2C21160B);
            check($sformatf("i_c%0d_wvalid", c), 64'(weights_valid), 64'd1);
        end
        next_cycle();

        // ---------------- simultaneous edges: weight wins ----------------
        load_input = 1'b1;
        weight_load(13'h100, 32'h2C21160B, 0);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            check($sformatf("sim_idle%0d_busy", c), 64'(busy), 64'd0);
            check($sformatf("sim_idle%0d_in_valid", c), 64'(in_valid), 64'd0);
            check($sformatf("sim_idle%0d_done", c), 64'(done), 64'd0);
        end
        load_input = 1'b0;
        next_cycle();

        // ---------------- address wrap, base 0x1FFE ----------------
        weight_load(13'h1FFE, 32'hA4A3A2A1, 0);
        next_cycle();

        // ---------------- input edge during weight load (cycle 2) ----------------
        weight_load(13'h020, 32'h04030201, 2);
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            check($sformatf("ign_idle%0d_busy", c), 64'(busy), 64'd0);
            check($sformatf("ign_idle%0d_done", c), 64'(done), 64'd0);
            check($sformatf("ign_idle%0d_in_valid", c), 64'(in_valid), 64'd0);
        end
        load_input = 1'b0;
        next_cycle();

        // ---------------- reset in cycle 3 of a weight load ----------------
        load_weight  = 1'b1;
        base_address = 13'h100;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            check($sformatf("ra_c%0d_busy", c), 64'(busy), 64'd1);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check("ra_busy", 64'(busy), 64'd0);
        check("ra_done", 64'(done), 64'd0);
        check("ra_rd_en", 64'(mem_rd_en), 64'd0);
        check("ra_addr", 64'(mem_addr), 64'd0);
        check("ra_wvalid", 64'(weights_valid), 64'd0);
        check("ra_weights", 64'(weight_out), 64'd0);
        check("ra_in_valid", 64'(in_valid), 64'd0);
        check("ra_in_data", 64'(in_data), 64'd0);
        // load_weight is still high: the load restarts from this cycle.
        weight_load(13'h100, 32'h2C21160B, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
